// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial add/subtract unit:
// FSM encodings and the nibble width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// Combinational 4-bit ripple adder with carry-in.
// c3 is the carry into the top bit, used for signed overflow.
module nibble_adder_cin
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    // Bit-by-bit ripple through the carry chain.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];
    assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one nibble per clock.
// Optional signed overflow: define NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW      = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t              state;
    logic [IW-1:0]       idx;
    logic                carry;
    logic [WIDTH-1:0]    opa;
    logic [WIDTH-1:0]    opb;
    int                  base;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] sum;
    logic                nib_cout;
    logic                nib_c3;

    // Select the operand slices for the current nibble index.
    always_comb begin
        base  = 32'(idx) * NIBBLE_W;
        a_nib = opa[base +: NIBBLE_W];
        b_nib = opb[base +: NIBBLE_W];
    end

    nibble_adder_cin u_nib (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (sum),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    assign busy = (state != IDLE);

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
    logic unused_c3;
    assign unused_c3 = nib_c3;
    assign overflow  = 1'b0;
`endif

    // Control FSM, operand latches, carry and result collection.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            Result   <= '0;
            c_out    <= 1'b0;
            done     <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa      <= A;
                        opb      <= sub ? ~B : B;
                        carry    <= sub;
                        idx      <= '0;
                        Result   <= '0;
                        c_out    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        overflow <= 1'b0;
`endif
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Result[base +: NIBBLE_W] <= sum;
                    carry <= nib_cout;
                    if (idx == LAST) begin
                        c_out    <= nib_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        overflow <= nib_c3 ^ nib_cout;
`endif
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
